// File: rtl/tt_sweep_ctrl_pkg.sv
// Shared definitions for the truth-table sweep controller.
//   sweep_state_e : FSM state encoding (IDLE=0, DRIVE=1, SAMPLE=2, DONE=3)
//   tt_width()    : truth-table width for an N-input unit (2**N)
//   cnt_width()   : register width needed to hold a DWELL-1 load value
package tt_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_e;

  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

  // Never narrower than one bit, even when DWELL=1 loads a value of 0.
  function automatic int cnt_width(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/tt_dwell_cnt.sv
// Loadable down-counter that times how long a vector is held.
//   clk, rst_n : clock, async active-low reset (count clears to 0)
//   load       : load DWELL-1 (has priority over dec)
//   dec        : decrement by one; holds at zero
//   zero       : count is zero
module tt_dwell_cnt
  import tt_sweep_ctrl_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = cnt_width(DWELL);
  localparam logic [CW-1:0] LOAD_VAL = CW'(DWELL - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: steps a combinational unit through every
// input vector, holds each for DWELL cycles, samples its f/g outputs on the
// following SAMPLE cycle, and compares the captured tables against expected
// tables latched at start.
//   clk, rst_n      : clock, async active-low reset
//   start           : begin a sweep (IDLE only)
//   abort           : cancel a sweep (DRIVE/SAMPLE only)
//   exp_f, exp_g    : expected tables, bit i = vector i (latched at start)
//   vec             : vector driven to the unit (msb=a ... lsb=d)
//   dut_f, dut_g    : unit outputs
//   busy            : sweep in progress
//   done            : one-cycle completion pulse
//   pass            : completed with no mismatch, held until next start
//   tt_f, tt_g      : captured tables
//   err_valid       : a mismatch has been seen
//   err_idx         : lowest mismatching vector index
//   state_dbg       : current FSM state
// Protocol: start is a single-cycle request accepted only while busy=0;
// completion is reported by exactly one done pulse, after which busy=0.
// An abort or reset ends the sweep with no done pulse.
module tt_sweep_ctrl
  import tt_sweep_ctrl_pkg::*;
#(
  parameter  int N_IN  = 4,
  parameter  int DWELL = 4,
  localparam int TT_W  = 1 << N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [TT_W-1:0] exp_f,
  input  logic [TT_W-1:0] exp_g,
  output logic [N_IN-1:0] vec,
  input  logic            dut_f,
  input  logic            dut_g,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [TT_W-1:0] tt_f,
  output logic [TT_W-1:0] tt_g,
  output logic            err_valid,
  output logic [N_IN-1:0] err_idx,
  output logic [1:0]      state_dbg
);

  localparam logic [N_IN-1:0] IDX_LAST = '1;
  localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);

  sweep_state_e    state, state_next;
  logic [N_IN-1:0] idx, idx_next;
  logic [TT_W-1:0] exp_f_q, exp_g_q;
  logic            cnt_load, cnt_dec, cnt_zero;
  logic            start_sweep, capture, finish, aborting;
  logic            mism, busy_next;

  tt_dwell_cnt #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  // Mismatch of the live unit outputs against the latched expectation.
  assign mism = (dut_f != exp_f_q[idx]) || (dut_g != exp_g_q[idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    start_sweep = 1'b0;
    capture     = 1'b0;
    finish      = 1'b0;
    aborting    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_sweep = 1'b1;
          cnt_load    = 1'b1;
          idx_next    = '0;
          state_next  = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (abort) begin
          aborting   = 1'b1;
          state_next = ST_IDLE;
        end else if (cnt_zero) begin
          state_next = ST_SAMPLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_SAMPLE: begin
        // Abort wins over the capture scheduled for this edge.
        if (abort) begin
          aborting   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          capture = 1'b1;
          if (idx == IDX_LAST) begin
            finish     = 1'b1;
            state_next = ST_DONE;
          end else begin
            idx_next   = idx + IDX_ONE;
            cnt_load   = 1'b1;
            state_next = ST_DRIVE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy_next = (state_next == ST_DRIVE) || (state_next == ST_SAMPLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      vec       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      exp_f_q   <= '0;
      exp_g_q   <= '0;
      tt_f      <= '0;
      tt_g      <= '0;
      err_valid <= 1'b0;
      err_idx   <= '0;
    end else begin
      idx  <= idx_next;
      vec  <= busy_next ? idx_next : '0;
      busy <= busy_next;
      done <= (state_next == ST_DONE);
      if (start_sweep) begin
        exp_f_q   <= exp_f;
        exp_g_q   <= exp_g;
        tt_f      <= '0;
        tt_g      <= '0;
        pass      <= 1'b0;
        err_valid <= 1'b0;
        err_idx   <= '0;
      end
      if (capture) begin
        tt_f[idx] <= dut_f;
        tt_g[idx] <= dut_g;
        if (mism && !err_valid) begin
          err_valid <= 1'b1;
          err_idx   <= idx;
        end
      end
      // The last sample lands on the same edge, so fold it in directly.
      if (finish)   pass <= !(err_valid || mism);
      if (aborting) pass <= 1'b0;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
module tb_tt_sweep_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, abort, sel;
  logic [15:0] exp_f, exp_g;

  // DUT with DWELL=4 (sel=0) and DUT with DWELL=1 (sel=1)
  logic [3:0]  vec4, vec1, err_idx4, err_idx1;
  logic        busy4, busy1, done4, done1, pass4, pass1, ev4, ev1;
  logic [15:0] tt_f4, tt_f1, tt_g4, tt_g1;
  logic [1:0]  st4, st1;
  logic        f4, g4, f1, g1;

  // Combinational unit under characterisation: f=a&b, g=c|d
  assign f4 = vec4[3] & vec4[2];
  assign g4 = vec4[1] | vec4[0];
  assign f1 = vec1[3] & vec1[2];
  assign g1 = vec1[1] | vec1[0];

  tt_sweep_ctrl #(.N_IN(4), .DWELL(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .abort(abort & ~sel),
    .exp_f(exp_f), .exp_g(exp_g), .vec(vec4), .dut_f(f4), .dut_g(g4),
    .busy(busy4), .done(done4), .pass(pass4), .tt_f(tt_f4), .tt_g(tt_g4),
    .err_valid(ev4), .err_idx(err_idx4), .state_dbg(st4)
  );

  tt_sweep_ctrl #(.N_IN(4), .DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .abort(abort & sel),
    .exp_f(exp_f), .exp_g(exp_g), .vec(vec1), .dut_f(f1), .dut_g(g1),
    .busy(busy1), .done(done1), .pass(pass1), .tt_f(tt_f1), .tt_g(tt_g1),
    .err_valid(ev1), .err_idx(err_idx1), .state_dbg(st1)
  );

  logic [3:0]  m_vec, m_err_idx;
  logic        m_busy, m_done, m_pass, m_ev;
  logic [15:0] m_tt_f, m_tt_g;
  logic [1:0]  m_st;
  assign m_vec     = sel ? vec1     : vec4;
  assign m_busy    = sel ? busy1    : busy4;
  assign m_done    = sel ? done1    : done4;
  assign m_pass    = sel ? pass1    : pass4;
  assign m_tt_f    = sel ? tt_f1    : tt_f4;
  assign m_tt_g    = sel ? tt_g1    : tt_g4;
  assign m_ev      = sel ? ev1      : ev4;
  assign m_err_idx = sel ? err_idx1 : err_idx4;
  assign m_st      = sel ? st1      : st4;

  // ---------------- scoreboard ----------------
  // entry = {tt_f, tt_g, pass, err_valid, err_idx}
  logic [37:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vec"},   m_vec,     0);
    chk({tag, "_busy"},  m_busy,    0);
    chk({tag, "_done"},  m_done,    0);
    chk({tag, "_pass"},  m_pass,    0);
    chk({tag, "_tt_f"},  m_tt_f,    0);
    chk({tag, "_tt_g"},  m_tt_g,    0);
    chk({tag, "_ev"},    m_ev,      0);
    chk({tag, "_eidx"},  m_err_idx, 0);
    chk({tag, "_state"}, m_st,      0);
  endtask

  // ---------------- driver ----------------
  // Starts a sweep on the selected DUT (start sampled at edge 0) and checks
  // busy/vec/done cycle by cycle. abort_at>0 drives abort in that cycle;
  // x1/x2 drive stray start pulses in those cycles.
  task automatic run_sweep(input logic [15:0] ef, input logic [15:0] eg,
                           input int abort_at, input int x1, input int x2);
    int          per, n_done, last;
    logic        aborted, ev, ps, busy_exp;
    logic [15:0] tf, tg;
    logic [3:0]  ei, iv;
    logic [37:0] r;
    per     = sel ? 2 : 5;
    n_done  = 16 * per + 1;
    aborted = (abort_at > 0);
    last    = aborted ? abort_at + 1 : n_done;
    tf = '0; tg = '0; ev = 1'b0; ei = '0; r = '0;
    // Vector i is captured on the edge ending cycle (i+1)*per.
    for (int i = 0; i < 16; i++) begin
      if (!aborted || ((i + 1) * per < abort_at)) begin
        iv    = 4'(i);
        tf[i] = iv[3] & iv[2];
        tg[i] = iv[1] | iv[0];
        if (!ev && ((tf[i] != ef[i]) || (tg[i] != eg[i]))) begin
          ev = 1'b1;
          ei = iv;
        end
      end
    end
    ps = !aborted && !ev;
    exp_q.push_back({tf, tg, ps, ev, ei});

    exp_f = ef;
    exp_g = eg;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_f = ~ef;   // must not affect a running sweep
    exp_g = ~eg;
    for (int c = 1; c <= last + 1; c++) begin
      busy_exp = aborted ? (c <= abort_at) : (c < n_done);
      chk("busy", m_busy, busy_exp);
      if (busy_exp) chk("vec", m_vec, (c - 1) / per);
      chk("done", m_done, (!aborted && (c == n_done)));
      if (c == last) begin
        chk("sb_size", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          r = exp_q.pop_front();
          chk("tt_f",      m_tt_f,    r[37:22]);
          chk("tt_g",      m_tt_g,    r[21:6]);
          chk("pass",      m_pass,    r[5]);
          chk("err_valid", m_ev,      r[4]);
          chk("err_idx",   m_err_idx, r[3:0]);
        end
      end
      if (c == last + 1) begin
        chk("vec_idle",  m_vec,  0);
        chk("pass_hold", m_pass, r[5]);
        chk("state_idle", m_st,  0);
      end
      start = (c == x1) || (c == x2);
      abort = (c == abort_at);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Reset pulled low in cycle 40 of a running sweep.
  task automatic reset_mid();
    exp_f = 16'hF000;
    exp_g = 16'hEEEE;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (39) tick();
    chk("pre_rst_busy", m_busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_async");
    tick();
    tick();
    chk_all_zero("rst_hold");
    #2 rst_n = 1'b1;
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    sel   = 1'b0;
    exp_f = '0;
    exp_g = '0;
    #12;
    chk_all_zero("reset4");
    sel = 1'b1;
    #1 chk_all_zero("reset1");
    sel = 1'b0;
    #9 rst_n = 1'b1;
    tick();

    // abort while idle is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", m_busy, 0);
    chk("idle_abort_state", m_st, 0);

    run_sweep(16'hF000, 16'hEEEE, 0, 0, 0);    // clean pass
    run_sweep(16'hF000, 16'hEEEF, 0, 0, 0);    // mismatch at 0
    run_sweep(16'hF800, 16'hEEEA, 0, 0, 0);    // mismatches at 2 and 11
    run_sweep(16'hF000, 16'hEEEE, 23, 0, 0);   // abort in vector 4 DRIVE
    reset_mid();
    run_sweep(16'hF000, 16'hEEEE, 0, 0, 0);    // clean sweep after reset

    sel = 1'b1;
    #1;
    run_sweep(16'hF000, 16'hEEEE, 0, 5, 20);   // DWELL=1, stray starts
    run_sweep(16'h0F00, 16'hEEEE, 0, 0, 0);    // DWELL=1, mismatch at 8

    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/tt_sweep_ctrl.md
Name: tt_sweep_ctrl

Overview:
Sequencer for a 4-input/2-output combinational unit (inputs a,b,c,d; outputs f,g).
- Walks the unit through all 2**N_IN input vectors, holding each for DWELL cycles before sampling.
- Captures both outputs into truth-table registers and compares them against expected tables latched at start.
- Reports done, pass and the first mismatching index.
- Sits beside the combinational unit as its built-in self-check and characterisation engine.

Parameters:
- N_IN, 4, input vector width; table width TT_W = 2**N_IN.
- DWELL, 4, cycles each vector is held before its sample cycle; legal range >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  begin sweep; honoured only in IDLE.
- abort  in  1  cancel sweep; honoured only in DRIVE/SAMPLE.
- exp_f  in  TT_W  expected f table; bit i corresponds to vector i.
- exp_g  in  TT_W  expected g table.
- vec  out  N_IN  drive to unit; vec[N_IN-1]=a ... vec[0]=d.
- dut_f  in  1  unit output f.
- dut_g  in  1  unit output g.
- busy  out  1  high in DRIVE and SAMPLE.
- done  out  1  one-cycle pulse at sweep completion.
- pass  out  1  sweep completed with zero mismatches; held until next start.
- tt_f  out  TT_W  captured f table.
- tt_g  out  TT_W  captured g table.
- err_valid  out  1  at least one mismatch seen.
- err_idx  out  N_IN  lowest vector index with an f or g mismatch.

Behaviour:
- Reset: every output 0, state IDLE, idx 0, dwell counter 0. Reset asserted mid-sweep clears everything asynchronously; no done is produced.
- Clock and reset: one clock; reset is asynchronous and active-low.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE with start=1:
  - latch exp_f and exp_g.
  - clear tt_f, tt_g, pass, err_valid and err_idx.
  - set idx=0 and cnt=DWELL-1.
  - go to DRIVE.
- DRIVE: vec=idx. If cnt!=0, decrement cnt; if cnt==0, go to SAMPLE.
- SAMPLE: vec=idx.
  - on the exit edge, tt_f[idx]<=dut_f and tt_g[idx]<=dut_g.
  - on mismatch against latched exp while err_valid==0: err_valid<=1, err_idx<=idx. Later mismatches do not overwrite err_idx.
  - if idx==TT_W-1, go to DONE; else idx++, cnt=DWELL-1, go to DRIVE.
- DONE (exactly one cycle):
  - done=1.
  - pass is set high on entry when err_valid==0 (visible during the done cycle) and holds until next start.
  - next state IDLE; vec returns to 0.
- Timing: with the start-sampling edge as cycle 0, vector i is held in cycles i*(DWELL+1)+1 through (i+1)*(DWELL+1). Its last cycle is SAMPLE. done is high in cycle TT_W*(DWELL+1)+1 (cycle 81 at the defaults).
- start outside IDLE is ignored; exp_* changes after the start edge are ignored.
- abort in DRIVE/SAMPLE:
  - next state IDLE, vec=0, done stays 0, pass=0.
  - tt_*, err_valid and err_idx keep their partial contents.
  - abort takes priority over a same-cycle SAMPLE capture (no capture).
- abort in IDLE/DONE is ignored; in DONE the done pulse still completes.
- idx wrap: the final idx increment never happens; DONE is entered from idx=TT_W-1.
- All outputs are registered; no combinational path from dut_f/dut_g to any output.

Decomposition:
- Shared include/package:
  - state encoding localparams (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3).
  - TT_W derivation.
- Sub-module tt_dwell_cnt: loadable down-counter with load value DWELL-1 and a zero flag; reused by other sequenced benches.
- FSM, capture and first-mismatch logic stay in tt_sweep_ctrl.

Test Plan:
- Unit f=a&b, g=c|d; exp_f=16'hF000, exp_g=16'hEEEE; DWELL=4; start at cycle 0 -> vec steps 0..15 every 5 cycles, done only in cycle 81, tt_f=16'hF000, tt_g=16'hEEEE, pass=1, err_valid=0.
- Same unit; exp_g=16'hEEEF -> pass=0, err_valid=1, err_idx=0; tt_g=16'hEEEE.
- Same unit; exp_f=16'hF800, exp_g=16'hEEEA -> err_idx=2 (lowest of mismatches at indices 2 and 11), pass=0.
- DWELL=1 build; start -> each vector held 2 cycles, done in cycle 33; extra start pulses at cycles 5 and 20 ignored, busy stays 1 through cycle 32.
- abort at cycle 23 (vector 4 in DRIVE) -> IDLE at cycle 24, vec=0, no done, pass=0; tt_f/tt_g hold bits 0..3 only.
- rst_n low at cycle 40 mid-sweep -> all outputs 0 immediately (before next edge); new start after release runs a full clean sweep with pass=1.
